// File: rtl/mmio_responder_pkg.sv
// Shared constants and types for the MMIO responder: register offsets,
// register bit positions and the switch debounce state encoding.
package mmio_pkg;

    localparam logic [2:0] MMIO_LED_OFS  = 3'd0;
    localparam logic [2:0] MMIO_SW_OFS   = 3'd1;
    localparam logic [2:0] MMIO_CNT_OFS  = 3'd2;
    localparam logic [2:0] MMIO_CMP_OFS  = 3'd3;
    localparam logic [2:0] MMIO_STAT_OFS = 3'd4;

    localparam int SW_LEVEL_BIT   = 0;
    localparam int SW_RISE_BIT    = 1;
    localparam int STAT_MATCH_BIT = 0;

    typedef enum logic [1:0] {
        DB_LOW  = 2'd0,
        DB_RISE = 2'd1,
        DB_HIGH = 2'd2,
        DB_FALL = 2'd3
    } db_state_t;

endpackage

// File: rtl/mmio_responder_if.sv
// Data-memory bus as seen by the MMIO window: the core is the master,
// the responder is the slave.
interface mmio_responder_if;

    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_hit;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, bus_hit
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, bus_hit
    );

endinterface

// File: rtl/mmio_responder_switch_debouncer.sv
// Two-flop synchroniser followed by a counting debounce FSM; outputs the
// debounced level and a one-cycle pulse on each debounced rising edge.
module switch_debouncer
    import mmio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic switch_in,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W:0] CNT_LIMIT = (CNT_W + 1)'(DEBOUNCE_CYCLES);

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W:0]   cnt_inc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // The transition fires on the clock where the count would reach the limit,
    // giving DEBOUNCE_CYCLES+2 clocks from pin edge to level change.
    always_comb begin
        sync1_d = switch_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        rise    = 1'b0;
        cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        case (state_q)
            DB_LOW: begin
                if (sync2_q) begin
                    state_d = DB_RISE;
                    cnt_d   = CNT_W'(1);
                end
            end
            DB_RISE: begin
                if (!sync2_q) begin
                    state_d = DB_LOW;
                end else if (cnt_inc >= CNT_LIMIT) begin
                    state_d = DB_HIGH;
                    rise    = 1'b1;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            DB_HIGH: begin
                if (!sync2_q) begin
                    state_d = DB_FALL;
                    cnt_d   = CNT_W'(1);
                end
            end
            DB_FALL: begin
                if (sync2_q) begin
                    state_d = DB_HIGH;
                end else if (cnt_inc >= CNT_LIMIT) begin
                    state_d = DB_LOW;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                end
            end
            default: state_d = DB_LOW;
        endcase
    end

    assign level = (state_q == DB_HIGH) || (state_q == DB_FALL);

endmodule

// File: rtl/mmio_responder.sv
// MMIO target for the core's data-memory bus: LED register, debounced switch
// and, when MMIO_TIMER_EN is defined, a free-running timer with compare match.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_FF00,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int          LED_W           = 4,
    parameter int          TIMER_W         = 32
) (
    input  logic             clock,
    input  logic             reset,
    mmio_responder_if.slave  bus,
    input  logic             switch_in,
    output logic [LED_W-1:0] led_out,
    output logic             timer_irq
);

    logic             hit;
    logic [2:0]       ofs;
    logic             wr_en;
    logic [LED_W-1:0] led_q, led_d;
    logic             sw_rise_q, sw_rise_d;
    logic             db_level;
    logic             db_rise;
    logic [31:0]      rdata;
    logic             unused_bits;

    assign hit   = (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
    assign ofs   = bus.bus_addr[4:2];
    assign wr_en = bus.bus_we & hit;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock     (clock),
        .reset     (reset),
        .switch_in (switch_in),
        .level     (db_level),
        .rise      (db_rise)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            sw_rise_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            sw_rise_q <= sw_rise_d;
        end
    end

    always_comb begin
        led_d     = led_q;
        sw_rise_d = sw_rise_q;
        if (wr_en && ofs == MMIO_LED_OFS) led_d = bus.bus_wdata[LED_W-1:0];
        if (wr_en && ofs == MMIO_SW_OFS && bus.bus_wdata[SW_RISE_BIT]) sw_rise_d = 1'b0;
        if (db_rise) sw_rise_d = 1'b1;
    end

`ifdef MMIO_TIMER_EN
    logic [TIMER_W-1:0] count_q, count_d;
    logic [TIMER_W-1:0] compare_q, compare_d;
    logic               match_q, match_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            compare_q <= '1;
            match_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end

    // Match compares the pre-increment count; a set beats a same-cycle W1C.
    always_comb begin
        count_d   = count_q + TIMER_W'(1);
        compare_d = compare_q;
        match_d   = match_q;
        if (wr_en && ofs == MMIO_CNT_OFS) count_d = bus.bus_wdata[TIMER_W-1:0];
        if (wr_en && ofs == MMIO_CMP_OFS) compare_d = bus.bus_wdata[TIMER_W-1:0];
        if (wr_en && ofs == MMIO_STAT_OFS && bus.bus_wdata[STAT_MATCH_BIT]) match_d = 1'b0;
        if (count_q == compare_q) match_d = 1'b1;
    end

    assign timer_irq = match_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (hit && bus.bus_re) begin
            case (ofs)
                MMIO_LED_OFS: rdata = 32'(led_q);
                MMIO_SW_OFS:  rdata = {30'd0, sw_rise_q, db_level};
`ifdef MMIO_TIMER_EN
                MMIO_CNT_OFS:  rdata = 32'(count_q);
                MMIO_CMP_OFS:  rdata = 32'(compare_q);
                MMIO_STAT_OFS: rdata = {31'd0, match_q};
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign bus.bus_rdata = rdata;
    assign bus.bus_hit   = hit;
    assign led_out       = led_q;
    assign unused_bits   = ^{bus.bus_addr[1:0], bus.bus_wdata};

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder; timer scenarios follow MMIO_TIMER_EN.
module tb_mmio_responder;

    localparam logic [31:0] BASE = 32'h0000_FF00;

    logic       clock = 1'b0;
    logic       reset;
    logic       switch_in;
    logic [3:0] led_out;
    logic       timer_irq;
    int         n_cmp = 0;
    int         n_bad = 0;

    mmio_responder_if bus_if ();

    mmio_responder dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_if),
        .switch_in (switch_in),
        .led_out   (led_out),
        .timer_irq (timer_irq)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        bus_if.bus_we    = 1'b1;
        @(posedge clock);
        #1;
        bus_if.bus_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_if.bus_addr = a;
        bus_if.bus_re   = 1'b1;
        #1;
        d = bus_if.bus_rdata;
        bus_if.bus_re = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        switch_in = 1'b0;
        bus_if.bus_addr = '0;
        bus_if.bus_wdata = '0;
        bus_if.bus_we = 1'b0;
        bus_if.bus_re = 1'b0;
        #1;
        n_cmp++; if (led_out !== 4'h0) begin n_bad++; $display("FAIL reset_led: got %h want 0", led_out); end
        n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
        step(2);
        rd(BASE + 32'h0, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_led_rd: got %h want 0", d); end
        rd(BASE + 32'h4, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_sw_rd: got %h want 0", d); end
`ifdef MMIO_TIMER_EN
        rd(BASE + 32'h8, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_count: got %h want 0", d); end
        rd(BASE + 32'hC, d);
        n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_compare: got %h want ffffffff", d); end
        rd(BASE + 32'h10, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0", d); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_led();
        logic [31:0] d;
        wr(BASE + 32'h0, 32'hFFFF_FFFA);
        n_cmp++; if (led_out !== 4'hA) begin n_bad++; $display("FAIL led_out: got %h want a", led_out); end
        rd(BASE + 32'h0, d);
        n_cmp++; if (d !== 32'h0000_000A) begin n_bad++; $display("FAIL led_rd: got %h want 0000000a", d); end
        rd(BASE + 32'h3, d);
        n_cmp++; if (d !== 32'h0000_000A) begin n_bad++; $display("FAIL led_rd_lowbits: got %h want 0000000a", d); end
        bus_if.bus_addr = BASE;
        bus_if.bus_re = 1'b0;
        #1;
        n_cmp++; if (bus_if.bus_rdata !== 32'h0) begin n_bad++; $display("FAIL rd_no_re: got %h want 0", bus_if.bus_rdata); end
        bus_if.bus_addr = 32'h0000_0100;
        bus_if.bus_wdata = 32'h5;
        bus_if.bus_we = 1'b1;
        #1;
        n_cmp++; if (bus_if.bus_hit !== 1'b0) begin n_bad++; $display("FAIL miss_hit: got %b want 0", bus_if.bus_hit); end
        @(posedge clock);
        #1;
        bus_if.bus_we = 1'b0;
        n_cmp++; if (led_out !== 4'hA) begin n_bad++; $display("FAIL miss_led: got %h want a", led_out); end
        bus_if.bus_addr = BASE + 32'h1C;
        #1;
        n_cmp++; if (bus_if.bus_hit !== 1'b1) begin n_bad++; $display("FAIL top_hit: got %b want 1", bus_if.bus_hit); end
        wr(BASE + 32'h14, 32'hFFFF_FFFF);
        rd(BASE + 32'h14, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ofs5_rd: got %h want 0", d); end
        n_cmp++; if (led_out !== 4'hA) begin n_bad++; $display("FAIL ofs5_led: got %h want a", led_out); end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] d;
        bus_if.bus_addr = BASE;
        bus_if.bus_wdata = 32'h5;
        bus_if.bus_we = 1'b1;
        bus_if.bus_re = 1'b1;
        #1;
        d = bus_if.bus_rdata;
        n_cmp++; if (d !== 32'hA) begin n_bad++; $display("FAIL rw_pre_value: got %h want 0000000a", d); end
        @(posedge clock);
        #1;
        bus_if.bus_we = 1'b0;
        bus_if.bus_re = 1'b0;
        n_cmp++; if (led_out !== 4'h5) begin n_bad++; $display("FAIL rw_led: got %h want 5", led_out); end
    endtask

    task automatic test_switch_glitch();
        logic [31:0] d;
        logic [31:0] seen;
        seen = '0;
        switch_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            rd(BASE + 32'h4, d);
            seen |= d;
        end
        switch_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            rd(BASE + 32'h4, d);
            seen |= d;
        end
        n_cmp++; if (seen !== 32'h0) begin n_bad++; $display("FAIL sw_glitch: got %h want 0", seen); end
    endtask

    task automatic test_bounce();
        logic [31:0] d;
        logic [31:0] seen;
        seen = '0;
        for (int i = 0; i < 40; i++) begin
            switch_in = ((i / 3) % 2 == 0);
            step(1);
            rd(BASE + 32'h4, d);
            seen |= d;
        end
        switch_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            rd(BASE + 32'h4, d);
            seen |= d;
        end
        n_cmp++; if (seen !== 32'h0) begin n_bad++; $display("FAIL sw_bounce: got %h want 0", seen); end
    endtask

    task automatic test_switch_hold();
        logic [31:0] d;
        switch_in = 1'b1;
        step(17);
        rd(BASE + 32'h4, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL sw_hold_17: got %h want 0", d); end
        step(1);
        rd(BASE + 32'h4, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL sw_hold_18: got %h want 3", d); end
        wr(BASE + 32'h4, 32'h2);
        rd(BASE + 32'h4, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL sw_clear: got %h want 1", d); end
    endtask

    task automatic test_timer();
        logic [31:0] d;
`ifdef MMIO_TIMER_EN
        wr(BASE + 32'h8, 32'd100);
        wr(BASE + 32'hC, 32'd5);
        wr(BASE + 32'h8, 32'd0);
        step(5);
        n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", timer_irq); end
        step(1);
        n_cmp++; if (timer_irq !== 1'b1) begin n_bad++; $display("FAIL irq_match: got %b want 1", timer_irq); end
        rd(BASE + 32'h10, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL status_rd: got %h want 1", d); end
        wr(BASE + 32'h10, 32'h1);
        n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL irq_w1c: got %b want 0", timer_irq); end
        wr(BASE + 32'h8, 32'd5);
        rd(BASE + 32'h8, d);
        n_cmp++; if (d !== 32'd5) begin n_bad++; $display("FAIL count_rd: got %h want 5", d); end
        wr(BASE + 32'h10, 32'h1);
        n_cmp++; if (timer_irq !== 1'b1) begin n_bad++; $display("FAIL irq_set_wins: got %b want 1", timer_irq); end
`else
        for (int k = 2; k <= 4; k++) begin
            wr(BASE + 32'(k * 4), 32'hFFFF_FFFF);
            rd(BASE + 32'(k * 4), d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL notimer_ofs%0d: got %h want 0", k, d); end
        end
        n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL notimer_irq: got %b want 0", timer_irq); end
`endif
    endtask

    task automatic test_timer_wrap();
        logic [31:0] d;
`ifdef MMIO_TIMER_EN
        wr(BASE + 32'h8, 32'h1000);
        wr(BASE + 32'hC, 32'h10);
        wr(BASE + 32'h10, 32'h1);
        n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL wrap_pre_irq: got %b want 0", timer_irq); end
        wr(BASE + 32'h8, 32'hFFFF_FFFF);
        rd(BASE + 32'h8, d);
        n_cmp++; if (d !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_load: got %h want ffffffff", d); end
        step(1);
        rd(BASE + 32'h8, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL wrap_zero: got %h want 0", d); end
        step(1);
        rd(BASE + 32'h8, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL wrap_one: got %h want 1", d); end
        n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL wrap_irq: got %b want 0", timer_irq); end
`else
        rd(BASE + 32'h8, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL notimer_count: got %h want 0", d); end
`endif
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] d;
        wr(BASE + 32'h0, 32'hF);
        switch_in = 1'b0;
        step(20);
        switch_in = 1'b1;
        step(9);
        n_cmp++; if (led_out !== 4'hF) begin n_bad++; $display("FAIL pre_reset_led: got %h want f", led_out); end
        reset = 1'b1;
        #1;
        n_cmp++; if (led_out !== 4'h0) begin n_bad++; $display("FAIL async_led: got %h want 0", led_out); end
        n_cmp++; if (timer_irq !== 1'b0) begin n_bad++; $display("FAIL async_irq: got %b want 0", timer_irq); end
        rd(BASE + 32'h4, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL async_sw: got %h want 0", d); end
        reset = 1'b0;
        step(17);
        rd(BASE + 32'h4, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL post_reset_17: got %h want 0", d); end
        step(1);
        rd(BASE + 32'h4, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL post_reset_18: got %h want 3", d); end
    endtask

    initial begin
        test_reset();
        test_led();
        test_rw_same_cycle();
        test_switch_glitch();
        test_bounce();
        test_switch_hold();
        test_timer();
        test_timer_wrap();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
